// File: rtl/boot_ctrl_if.sv
// Bus bundle for boot_ctrl: load stream, memory write ports, store snoop and run status.
// "slave" is the controller's view and "master" is the host/bench view.
interface boot_ctrl_if #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int CNT_W   = 32
);
  logic               ld_valid;
  logic               ld_ready;
  logic [31:0]        ld_data;
  logic               restart;
  logic [CNT_W-1:0]   timeout_cycles;
  logic               core_rst;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               snp_we;
  logic [31:0]        snp_addr;
  logic [31:0]        snp_wdata;
  logic               done;
  logic               pass;
  logic               timed_out;
  logic [31:0]        fail_code;
  logic [CNT_W-1:0]   run_cycles;
  logic [2:0]         state;

  modport slave (
    input  ld_valid, ld_data, restart, timeout_cycles, snp_we, snp_addr, snp_wdata,
    output ld_ready, core_rst, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
           dmem_wdata, done, pass, timed_out, fail_code, run_cycles, state
  );

  modport master (
    output ld_valid, ld_data, restart, timeout_cycles, snp_we, snp_addr, snp_wdata,
    input  ld_ready, core_rst, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
           dmem_wdata, done, pass, timed_out, fail_code, run_cycles, state
  );
endinterface

// File: rtl/boot_ctrl.sv
// Boot/run controller: streams header+data words into imem/dmem, sequences the core
// reset, then watches core stores for a tohost result or a run-cycle timeout.
module boot_ctrl #(
  parameter int          IMEM_AW     = 8,
  parameter int          DMEM_AW     = 8,
  parameter int          RST_CYCLES  = 4,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC,
  parameter int          CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  boot_ctrl_if.slave bus
);
  // One address register wide enough for either target; each port takes its low bits,
  // which gives the modulo-2^AW wrap for free.
  localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state, w_nstate;
  logic               r_tgt;
  logic [AW-1:0]      r_addr;
  logic [15:0]        r_rem;
  logic [31:0]        r_hold;
  logic [CNT_W-1:0]   r_run;
  logic               r_core_rst, r_done, r_pass, r_timed_out;
  logic [31:0]        r_fail_code;
  logic               r_imem_we, r_dmem_we;
  logic [IMEM_AW-1:0] r_imem_addr;
  logic [DMEM_AW-1:0] r_dmem_addr;
  logic [31:0]        r_imem_wdata, r_dmem_wdata;

  logic               w_ready, w_acc, w_tohost, w_tmo;
  logic [CNT_W-1:0]   w_run_inc;

  assign w_ready   = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_acc     = bus.ld_valid && w_ready;
  assign w_tohost  = bus.snp_we && (bus.snp_addr == TOHOST_ADDR);
  assign w_run_inc = r_run + CNT_W'(1);
  // Compared against the post-increment count so DONE lands with run_cycles == limit.
  assign w_tmo     = (bus.timeout_cycles != '0) && (w_run_inc == bus.timeout_cycles);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HDR;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_core_rst <= (w_nstate != S_RUN);
      r_done     <= (w_nstate == S_DONE);
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_HDR: begin
        if (w_acc) begin
          if (bus.ld_data[15:0] == 16'd0) w_nstate = S_HOLD;
          else                            w_nstate = S_DATA;
        end
      end
      S_DATA: if (w_acc && (r_rem == 16'd1)) w_nstate = S_HDR;
      S_HOLD: if (r_hold == 32'd0) w_nstate = S_RUN;
      S_RUN:  if (w_tohost || w_tmo) w_nstate = S_DONE;
      S_DONE: if (bus.restart) w_nstate = S_HDR;
      default: w_nstate = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tgt        <= 1'b0;
      r_addr       <= '0;
      r_rem        <= '0;
      r_hold       <= '0;
      r_run        <= '0;
      r_pass       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_fail_code  <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      unique case (r_state)
        S_HDR: begin
          if (w_acc) begin
            r_tgt  <= bus.ld_data[31];
            r_addr <= AW'(bus.ld_data[30:16]);
            r_rem  <= bus.ld_data[15:0];
            r_hold <= 32'(RST_CYCLES - 1);
          end
        end
        S_DATA: begin
          if (w_acc) begin
            if (r_tgt) begin
              r_dmem_we    <= 1'b1;
              r_dmem_addr  <= r_addr[DMEM_AW-1:0];
              r_dmem_wdata <= bus.ld_data;
            end else begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_addr[IMEM_AW-1:0];
              r_imem_wdata <= bus.ld_data;
            end
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - 16'd1;
          end
        end
        S_HOLD: if (r_hold != 32'd0) r_hold <= r_hold - 32'd1;
        S_RUN: begin
          if (!(&r_run)) r_run <= w_run_inc;
          if (w_tohost) begin
            r_pass      <= (bus.snp_wdata == 32'd1);
            r_fail_code <= bus.snp_wdata;
          end else if (w_tmo) begin
            r_timed_out <= 1'b1;
            r_pass      <= 1'b0;
          end
        end
        S_DONE: begin
          if (bus.restart) begin
            r_run       <= '0;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
            r_fail_code <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_ready   = w_ready;
  assign bus.core_rst   = r_core_rst;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.timed_out  = r_timed_out;
  assign bus.fail_code  = r_fail_code;
  assign bus.run_cycles = r_run;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_boot_ctrl.sv
// Directed-plus-random bench for boot_ctrl: expected memory writes come from the header
// arithmetic, run/hold lengths from cycle counting in the bench.
module tb_boot_ctrl;
  localparam int          IAW    = 8;
  localparam int          DAW    = 8;
  localparam int          RSTC   = 4;
  localparam int          CW     = 32;
  localparam logic [31:0] TOHOST = 32'h0000_00FC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  boot_ctrl_if #(.IMEM_AW(IAW), .DMEM_AW(DAW), .CNT_W(CW)) bus ();

  boot_ctrl #(
    .IMEM_AW(IAW), .DMEM_AW(DAW), .RST_CYCLES(RSTC), .TOHOST_ADDR(TOHOST), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {target, word address, data}
  logic [40:0] exp_q[$];
  logic [40:0] obs_q[$];

  always @(negedge clk) begin
    if (bus.imem_we) obs_q.push_back({1'b0, bus.imem_addr, bus.imem_wdata});
    if (bus.dmem_we) obs_q.push_back({1'b1, bus.dmem_addr, bus.dmem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic snoop_junk();
    logic [31:0] a;
    a = $urandom;
    if (a == TOHOST) a = 32'h0;
    bus.snp_we    = $urandom_range(0, 1);
    bus.snp_addr  = a;
    bus.snp_wdata = 32'd1;
  endtask

  task automatic snoop_off();
    bus.snp_we    = 1'b0;
    bus.snp_addr  = '0;
    bus.snp_wdata = '0;
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic send(input logic [31:0] d, input bit stall);
    int n;
    if (stall) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = $urandom;
        tick();
      end
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    n = 0;
    while (!bus.ld_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ld_ready_wait", 64'(n), 64'd0);
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_block(input logic [31:0] hdr, input bit stall);
    logic        tgt;
    int          base, cnt, a;
    logic [31:0] d;
    logic [7:0]  a8;
    tgt  = hdr[31];
    base = int'(hdr[30:16]);
    cnt  = int'(hdr[15:0]);
    send(hdr, stall);
    for (int i = 0; i < cnt; i++) begin
      d  = $urandom;
      a  = (base + i) % (tgt ? (1 << DAW) : (1 << IAW));
      a8 = a[7:0];
      exp_q.push_back({tgt, a8, d});
      send(d, stall);
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_entry"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Sends the N=0 header and counts reset-hold cycles; returns in the first RUN cycle.
  task automatic start_run();
    int hold;
    send(32'h0, 1'b0);
    hold = 0;
    while (bus.core_rst && hold < 100) begin
      hold++;
      tick();
    end
    chk("hold_cycles", 64'(hold), 64'(RSTC));
    chk("run_state", 64'(bus.state), 64'd3);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("rs_state", 64'(bus.state), 64'd0);
    chk("rs_done", 64'(bus.done), 64'd0);
    chk("rs_pass", 64'(bus.pass), 64'd0);
    chk("rs_tmo", 64'(bus.timed_out), 64'd0);
    chk("rs_code", 64'(bus.fail_code), 64'd0);
    chk("rs_runc", 64'(bus.run_cycles), 64'd0);
    chk("rs_ready", 64'(bus.ld_ready), 64'd1);
  endtask

  initial begin
    int          n, cnt;
    logic [31:0] wa, wb;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.restart  = 1'b0;
    bus.timeout_cycles = '0;
    snoop_off();

    repeat (3) tick();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_core_rst", 64'(bus.core_rst), 64'd1);
    chk("rst_imem_we", 64'(bus.imem_we), 64'd0);
    chk("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_tmo", 64'(bus.timed_out), 64'd0);
    chk("rst_code", 64'(bus.fail_code), 64'd0);
    chk("rst_runc", 64'(bus.run_cycles), 64'd0);
    chk("rst_ready", 64'(bus.ld_ready), 64'd1);
    rst = 1'b1;
    tick();

    // dmem load of two words with explicit write-port latency checks
    wa = $urandom;
    wb = $urandom;
    send(32'h8000_0002, 1'b0);
    chk("a_data_state", 64'(bus.state), 64'd1);
    send(wa, 1'b0);
    chk("a_we0", 64'(bus.dmem_we), 64'd1);
    chk("a_addr0", 64'(bus.dmem_addr), 64'd0);
    chk("a_wd0", 64'(bus.dmem_wdata), 64'(wa));
    send(wb, 1'b0);
    chk("a_we1", 64'(bus.dmem_we), 64'd1);
    chk("a_addr1", 64'(bus.dmem_addr), 64'd1);
    chk("a_wd1", 64'(bus.dmem_wdata), 64'(wb));
    chk("a_hdr_state", 64'(bus.state), 64'd0);
    exp_q.push_back({1'b1, 8'd0, wa});
    exp_q.push_back({1'b1, 8'd1, wb});
    start_run();
    check_writes("a_writes");

    // restart outside DONE is ignored; then tohost pass after random junk snoops
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("a_restart_ign", 64'(bus.state), 64'd3);
    n = $urandom_range(3, 10);
    for (int i = 0; i < n; i++) begin
      snoop_junk();
      tick();
    end
    bus.snp_we = 1'b1; bus.snp_addr = TOHOST; bus.snp_wdata = 32'd1;
    tick();
    snoop_off();
    chk("a_done", 64'(bus.done), 64'd1);
    chk("a_pass", 64'(bus.pass), 64'd1);
    chk("a_code", 64'(bus.fail_code), 64'd1);
    chk("a_core_rst", 64'(bus.core_rst), 64'd1);
    chk("a_runc", 64'(bus.run_cycles), 64'(n + 2));
    // DONE holds status and ignores both the load stream and the snoop
    bus.ld_valid = 1'b1;
    bus.snp_we = 1'b1; bus.snp_addr = TOHOST; bus.snp_wdata = 32'd7;
    tick();
    bus.ld_valid = 1'b0;
    snoop_off();
    chk("a_hold_code", 64'(bus.fail_code), 64'd1);
    chk("a_hold_state", 64'(bus.state), 64'd4);
    chk("a_hold_ready", 64'(bus.ld_ready), 64'd0);
    do_restart();

    // imem load that wraps past the top of the address space
    load_block(32'h00FE_0004, 1'b0);
    chk("b_hdr_state", 64'(bus.state), 64'd0);
    start_run();
    check_writes("b_writes");
    bus.snp_we = 1'b1; bus.snp_addr = TOHOST; bus.snp_wdata = 32'd7;
    tick();
    snoop_off();
    chk("b_done", 64'(bus.done), 64'd1);
    chk("b_pass", 64'(bus.pass), 64'd0);
    chk("b_code", 64'(bus.fail_code), 64'd7);
    do_restart();

    // timeout with only junk snoops
    bus.timeout_cycles = CW'(20);
    start_run();
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      snoop_junk();
      tick();
      cnt++;
    end
    snoop_off();
    chk("t_cycles", 64'(cnt), 64'd20);
    chk("t_tmo", 64'(bus.timed_out), 64'd1);
    chk("t_pass", 64'(bus.pass), 64'd0);
    chk("t_runc", 64'(bus.run_cycles), 64'd20);
    do_restart();

    // tohost on the same cycle the timeout would fire
    start_run();
    repeat (19) tick();
    chk("tt_not_done", 64'(bus.done), 64'd0);
    bus.snp_we = 1'b1; bus.snp_addr = TOHOST; bus.snp_wdata = 32'd1;
    tick();
    snoop_off();
    chk("tt_done", 64'(bus.done), 64'd1);
    chk("tt_pass", 64'(bus.pass), 64'd1);
    chk("tt_tmo", 64'(bus.timed_out), 64'd0);
    chk("tt_runc", 64'(bus.run_cycles), 64'd20);
    do_restart();
    bus.timeout_cycles = '0;

    // stalled 16-word load, then an immediate header; tohost snoop held active throughout
    bus.snp_we = 1'b1; bus.snp_addr = TOHOST; bus.snp_wdata = 32'd1;
    wa = $urandom;
    load_block({1'b1, 7'd0, wa[7:0], 16'd16}, 1'b1);
    load_block(32'h8040_0003, 1'b0);
    tick();
    tick();
    check_writes("s_writes");
    chk("s_not_done", 64'(bus.done), 64'd0);
    chk("s_state", 64'(bus.state), 64'd0);
    snoop_off();

    // async reset in the middle of a data burst
    send(32'h0010_0010, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    chk("r_we_before", 64'(bus.imem_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("r_state", 64'(bus.state), 64'd0);
    chk("r_imem_we", 64'(bus.imem_we), 64'd0);
    chk("r_core_rst", 64'(bus.core_rst), 64'd1);
    tick();
    rst = 1'b1;
    obs_q.delete();
    exp_q.delete();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Synthesizable boot and run controller for the RISC-V processor. It replaces fixed file-based memory initialisation and a timed reset/finish with a streamed loader, a programmable reset sequencer and an end-of-test monitor. It sits between a load stream (host, UART bridge or bench) and the core's `inst_mem`/`data_mem` write ports, and drives the core's active-high `rst`. It holds the core in reset while loading, releases it, and watches data-memory writes for a pass/fail result or a timeout.

## Interface
- `IMEM_AW`, default 8: instruction memory word-address width.
- `DMEM_AW`, default 8: data memory word-address width.
- `RST_CYCLES`, default 4: core-reset hold cycles after load completes, minimum 1.
- `TOHOST_ADDR`, default 32'h0000_00FC: byte address whose write ends the test.
- `CNT_W`, default 32: width of the run-cycle counter and the timeout limit.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `ld_valid` in 1 / `ld_ready` out 1 / `ld_data` in 32: load stream, transfers when valid&&ready.
- `restart` in 1: single-cycle pulse that restarts loading from DONE.
- `timeout_cycles` in CNT_W: run limit; 0 disables the timeout.
- `core_rst` out 1: active-high reset to the processor.
- `imem_we` out 1, `imem_addr` out IMEM_AW, `imem_wdata` out 32: instruction memory write port.
- `dmem_we` out 1, `dmem_addr` out DMEM_AW, `dmem_wdata` out 32: data memory write port (load only).
- `snp_we` in 1, `snp_addr` in 32, `snp_wdata` in 32: snoop of the core's data-memory store port.
- `done` out 1, `pass` out 1, `timed_out` out 1, `fail_code` out 32, `run_cycles` out CNT_W, `state` out 3.

## Operation
- States are HDR(0), DATA(1), HOLD(2), RUN(3), DONE(4).
- Reset values: state=HDR, `core_rst`=1, all write enables 0, addresses and wdata 0, `done`/`pass`/`timed_out` 0, `fail_code` 0, `run_cycles` 0.
- HDR: `ld_ready`=1. Each accepted word is a header:
  - bit31 selects the target: 0 = imem, 1 = dmem.
  - bits[30:16] give the base word address, truncated to the target's AW.
  - bits[15:0] give the count N.
  - N≠0 → DATA with remaining=N and addr=base.
  - N=0 → HOLD; the hold counter loads RST_CYCLES−1.
- DATA: `ld_ready`=1. Each accepted word is written to the selected memory at addr.
  - addr increments modulo 2^AW, so wrap-around is silent and legal.
  - remaining decrements; the accept that brings it to 0 → HDR.
  - Zero-valid cycles (stalls) are allowed anywhere; no timeout applies during load.
- HOLD: `ld_ready`=0, `core_rst`=1. The counter decrements each cycle; when it reaches 0 → RUN.
- RUN: `core_rst`=0 and `run_cycles` increments by 1 per cycle, saturating at all-ones.
  - A snoop write (`snp_we`=1) with `snp_addr`==TOHOST_ADDR → DONE, `pass`=(`snp_wdata`==1), `fail_code`=`snp_wdata`.
  - Otherwise, if `timeout_cycles`≠0 and `run_cycles`+1==`timeout_cycles` → DONE with `timed_out`=1 and `pass`=0.
  - A tohost write and the timeout in the same cycle: tohost wins and `timed_out` stays 0.
  - Snoop writes to other addresses are ignored. Snoop is ignored in every state other than RUN.
- DONE: `done`=1, `core_rst`=1, `ld_ready`=0, and all status is held.
  - `restart` → HDR and clears `done`, `pass`, `timed_out`, `fail_code` and `run_cycles`.
  - `restart` in any other state is ignored.
- Asserting `rst` in any state returns to the reset values immediately. Memory contents are not cleared.

## Timing
- Write ports are registered. A word accepted on edge k appears as `*_we`=1 with its addr/wdata during cycle k+1, and `*_we` falls the cycle after unless another word was accepted.
- `ld_ready` is a combinational function of state only.
- After the N=0 header, `core_rst` stays 1 for exactly RST_CYCLES cycles in HOLD, then falls on entry to RUN.
- `run_cycles`=1 in the first RUN cycle's registered value.
- `done` rises the cycle after the terminating snoop write or timeout edge, and `core_rst` rises with it.
- Back-to-back accepts are sustained at one word per cycle, including a header immediately after the last data word.

## Test plan
- Load `80000002` then words A, B, then header `00000000`. Required: dmem writes A@0, B@1; `core_rst` high for 4 cycles then low.
- Load `00FE0004` then 4 words. Required: imem addresses 254, 255, 0, 1 (wrap), then HDR.
- In RUN, snoop a write of 1 to 0xFC. Required: `done`=1, `pass`=1, `fail_code`=1, `core_rst`=1. A write of 7 instead gives `pass`=0 and `fail_code`=7.
- `timeout_cycles`=20 with no tohost write. Required: `done`, `timed_out`, `run_cycles`=20. A tohost write on cycle 20 gives `pass` and `timed_out`=0.
- Pulse `restart` in DONE. Required: status cleared, `ld_ready`=1. Then drop `rst` mid-DATA: state=HDR and `imem_we`=0 immediately.
- Drive random `ld_valid` stalls during a 16-word load. Required: exactly 16 writes in order with no duplicates.
